// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address and selects the next PC from
// increment, relative branch, absolute jump, call or return (internal return stack).
module pc_unit #(
    parameter int               WIDTH       = 16,
    parameter int               INC         = 2,
    parameter int               STACK_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
    localparam int              DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] offset,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] next_seq,
    output logic [WIDTH-1:0] ret_addr,
    output logic [DW-1:0]    depth,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             fault
);

    localparam int               AW       = $clog2(STACK_DEPTH);
    localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
    localparam logic [DW-1:0]    FULL_CNT = DW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_INC    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             fault_q, fault_d;
    logic             push;
    logic [DW-1:0]    topIdx;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    assign next_seq    = pc_q + INC_W;
    assign stack_full  = (depth_q == FULL_CNT);
    assign stack_empty = (depth_q == '0);
    assign topIdx      = depth_q - DW'(1);
    // Stale RAM contents stay hidden: an empty stack always reads as zero.
    assign ret_addr    = stack_empty ? '0 : stack_q[topIdx[AW-1:0]];
    assign out         = pc_q;
    assign depth       = depth_q;
    assign fault       = fault_q;

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        fault_d = fault_q;
        push    = 1'b0;
        if (PCWrite) begin
            case (op)
                OP_INC:    pc_d = pc_q + INC_W;
                OP_BRANCH: pc_d = pc_q + offset;
                OP_JUMP:   pc_d = target;
                OP_CALL: begin
                    if (stack_full) begin
                        fault_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        depth_d = depth_q + DW'(1);
                        pc_d    = target;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        fault_d = 1'b1;
                    end else begin
                        depth_d = topIdx;
                        pc_d    = ret_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_ADDR;
            depth_q <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            fault_q <= fault_d;
        end
    end

    // Return-address RAM has no reset; the depth counter alone defines validity.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            stack_q[depth_q[AW-1:0]] <= next_seq;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, stack overflow
// sequence and randomized ops against a queue-based reference model.
module tb_pc_unit;

    logic        clock;
    logic        reset;
    logic        PCWrite;
    logic [2:0]  op;
    logic [15:0] target;
    logic [15:0] offset;
    logic [15:0] out;
    logic [15:0] next_seq;
    logic [15:0] ret_addr;
    logic [3:0]  depth;
    logic        stack_full;
    logic        stack_empty;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [15:0] mPc;
    logic [15:0] mStack [$];
    bit          mFault;

    pc_unit dut (
        .clock      (clock),
        .reset      (reset),
        .PCWrite    (PCWrite),
        .op         (op),
        .target     (target),
        .offset     (offset),
        .out        (out),
        .next_seq   (next_seq),
        .ret_addr   (ret_addr),
        .depth      (depth),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .fault      (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        bit          we;
        logic [2:0]  op;
        logic [15:0] tgt;
        logic [15:0] off;
        logic [15:0] expOut;
        int          expDepth;
        bit          expFault;
    } vec_t;

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic modelStep(input bit rst, input bit we, input logic [2:0] o,
                             input logic [15:0] tgt, input logic [15:0] off);
        if (rst) begin
            mPc    = 16'h0000;
            mFault = 1'b0;
            mStack.delete();
        end else if (we) begin
            case (o)
                3'd0: mPc = mPc + 16'd2;
                3'd1: mPc = mPc + off;
                3'd2: mPc = tgt;
                3'd3: begin
                    if (mStack.size() == 8) mFault = 1'b1;
                    else begin
                        mStack.push_back(mPc + 16'd2);
                        mPc = tgt;
                    end
                end
                3'd4: begin
                    if (mStack.size() == 0) mFault = 1'b1;
                    else mPc = mStack.pop_back();
                end
                default: ;
            endcase
        end
    endtask

    task automatic checkOutput();
        logic [15:0] expSeq;
        logic [15:0] expRet;
        expSeq = mPc + 16'd2;
        expRet = (mStack.size() == 0) ? 16'h0000 : mStack[$];
        checkVal("out",         int'(out),         int'(mPc));
        checkVal("depth",       int'(depth),       mStack.size());
        checkVal("ret_addr",    int'(ret_addr),    int'(expRet));
        checkVal("next_seq",    int'(next_seq),    int'(expSeq));
        checkVal("stack_full",  int'(stack_full),  int'(mStack.size() == 8));
        checkVal("stack_empty", int'(stack_empty), int'(mStack.size() == 0));
        checkVal("fault",       int'(fault),       int'(mFault));
    endtask

    task automatic applyStimulus(input bit rst, input bit we, input logic [2:0] o,
                                 input logic [15:0] tgt, input logic [15:0] off);
        reset   = rst;
        PCWrite = we;
        op      = o;
        target  = tgt;
        offset  = off;
        @(posedge clock);
        modelStep(rst, we, o, tgt, off);
        #1;
        checkOutput();
    endtask

    vec_t vecs [$];

    initial begin
        reset = 1'b1; PCWrite = 1'b0; op = 3'd0; target = '0; offset = '0;
        mPc = 16'h0000; mFault = 1'b0;

        vecs = '{
            '{1, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0},
            '{0, 1, 3'd0, 16'h0000, 16'h0000, 16'h0002, 0, 0},
            '{0, 1, 3'd0, 16'h0000, 16'h0000, 16'h0004, 0, 0},
            '{0, 1, 3'd0, 16'h0000, 16'h0000, 16'h0006, 0, 0},
            '{0, 1, 3'd2, 16'h0010, 16'h0000, 16'h0010, 0, 0},
            '{0, 1, 3'd1, 16'h0000, 16'hFFF0, 16'h0000, 0, 0},
            '{0, 1, 3'd2, 16'hFFFE, 16'h0000, 16'hFFFE, 0, 0},
            '{0, 1, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0},
            '{0, 0, 3'd2, 16'h1234, 16'h0000, 16'h0000, 0, 0},
            '{0, 1, 3'd2, 16'h0100, 16'h0000, 16'h0100, 0, 0},
            '{0, 1, 3'd3, 16'h0200, 16'h0000, 16'h0200, 1, 0},
            '{0, 1, 3'd3, 16'h0300, 16'h0000, 16'h0300, 2, 0},
            '{0, 1, 3'd4, 16'h0000, 16'h0000, 16'h0202, 1, 0},
            '{0, 1, 3'd4, 16'h0000, 16'h0000, 16'h0102, 0, 0},
            '{0, 1, 3'd4, 16'h0000, 16'h0000, 16'h0102, 0, 1},
            '{0, 1, 3'd6, 16'h5555, 16'h0004, 16'h0102, 0, 1},
            '{0, 1, 3'd0, 16'h0000, 16'h0000, 16'h0104, 0, 1},
            '{0, 1, 3'd3, 16'h0400, 16'h0000, 16'h0400, 1, 1},
            '{1, 1, 3'd3, 16'h0800, 16'h0000, 16'h0000, 0, 0}
        };

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].op, vecs[i].tgt, vecs[i].off);
            checkVal($sformatf("vec%0d_out", i),   int'(out),   int'(vecs[i].expOut));
            checkVal($sformatf("vec%0d_depth", i), int'(depth), vecs[i].expDepth);
            checkVal($sformatf("vec%0d_fault", i), int'(fault), int'(vecs[i].expFault));
        end

        // Nested call depth check: return address of the inner call.
        applyStimulus(0, 1, 3'd2, 16'h0100, 16'h0000);
        applyStimulus(0, 1, 3'd3, 16'h0200, 16'h0000);
        applyStimulus(0, 1, 3'd3, 16'h0300, 16'h0000);
        checkVal("nest_ret_addr", int'(ret_addr), 16'h0202);
        checkVal("nest_depth",    int'(depth),    2);

        // Overflow: fill the stack, then one extra CALL, then unwind.
        applyStimulus(1, 0, 3'd0, 16'h0000, 16'h0000);
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1, 3'd3, 16'h1000 + 16'(i * 16), 16'h0000);
        checkVal("ovf_full",  int'(stack_full), 1);
        checkVal("ovf_fault0", int'(fault),     0);
        applyStimulus(0, 1, 3'd3, 16'h9000, 16'h0000);
        checkVal("ovf_out",   int'(out),   16'h1070);
        checkVal("ovf_depth", int'(depth), 8);
        checkVal("ovf_fault", int'(fault), 1);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(0, 1, 3'd4, 16'h0000, 16'h0000);
            checkVal($sformatf("unwind%0d_out", i),
                     int'(out), (i == 0) ? 16'h0002 : 16'h1000 + (i - 1) * 16 + 2);
            checkVal($sformatf("unwind%0d_fault", i), int'(fault), 1);
        end

        // Randomized ops against the reference model.
        applyStimulus(1, 0, 3'd0, 16'h0000, 16'h0000);
        for (int n = 0; n < 600; n++) begin
            bit          rst;
            bit          we;
            logic [2:0]  o;
            int          r;
            r   = $urandom_range(0, 99);
            rst = ($urandom_range(0, 99) < 2);
            we  = ($urandom_range(0, 99) < 85);
            if (r < 15)      o = 3'd0;
            else if (r < 25) o = 3'd1;
            else if (r < 35) o = 3'd2;
            else if (r < 65) o = 3'd3;
            else if (r < 93) o = 3'd4;
            else             o = 3'($urandom_range(5, 7));
            applyStimulus(rst, we, o, 16'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
